// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory between fetch and load/store.
// Sequences each access through the fixed read latency and drives stalls.
module mem_port_arbiter #(
  parameter int ADDR       = 32,
  parameter int W_OPR      = 32,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             if_req_i,
  input  logic [ADDR-1:0]  if_addr_i,
  output logic             if_stall_o,
  output logic             if_rvalid_o,
  output logic [W_OPR-1:0] if_rdata_o,
  input  logic             ls_req_i,
  input  logic             ls_write_i,
  input  logic [ADDR-1:0]  ls_addr_i,
  input  logic [W_OPR-1:0] ls_wdata_i,
  output logic             ls_stall_o,
  output logic             ls_rvalid_o,
  output logic [W_OPR-1:0] ls_rdata_o,
  output logic             mem_req_o,
  output logic             mem_write_o,
  output logic [ADDR-1:0]  mem_addr_o,
  output logic [W_OPR-1:0] mem_wdata_o,
  input  logic [W_OPR-1:0] mem_rdata_i,
  output logic             busy_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  localparam logic [3:0] LAT  = 4'(MEM_LAT);
  localparam logic [3:0] SMAX = 4'(STARVE_MAX);

  state_t           state_q, state_d;
  logic             owner_q, owner_d;
  logic [3:0]       lat_q, lat_d;
  logic [3:0]       starve_q, starve_d;
  logic             abort_q, abort_d;
  logic             mreq_q, mreq_d;
  logic             mwr_q, mwr_d;
  logic [ADDR-1:0]  maddr_q, maddr_d;
  logic [W_OPR-1:0] mwdata_q, mwdata_d;

  logic done;
  logic owner_req;
  logic grant_if;
  logic if_hit;
  logic ls_hit;

  assign done      = (state_q == WAIT) && (lat_q == 4'd1);
  assign owner_req = owner_q ? ls_req_i : if_req_i;
  assign grant_if  = if_req_i & (~ls_req_i | (starve_q == SMAX));

  // State and registered memory-side outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      owner_q  <= 1'b0;
      lat_q    <= 4'd0;
      starve_q <= 4'd0;
      abort_q  <= 1'b0;
      mreq_q   <= 1'b0;
      mwr_q    <= 1'b0;
      maddr_q  <= '0;
      mwdata_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      lat_q    <= lat_d;
      starve_q <= starve_d;
      abort_q  <= abort_d;
      mreq_q   <= mreq_d;
      mwr_q    <= mwr_d;
      maddr_q  <= maddr_d;
      mwdata_q <= mwdata_d;
    end
  end

  // Next-state: arbitration in IDLE, latency count in WAIT
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    lat_d    = lat_q;
    starve_d = starve_q;
    abort_d  = abort_q;
    mreq_d   = mreq_q;
    mwr_d    = mwr_q;
    maddr_d  = maddr_q;
    mwdata_d = mwdata_q;
    unique case (state_q)
      IDLE: begin
        if (if_req_i | ls_req_i) begin
          state_d = ISSUE;
          abort_d = 1'b0;
          mreq_d  = 1'b1;
          if (grant_if) begin
            owner_d  = 1'b0;
            mwr_d    = 1'b0;
            maddr_d  = if_addr_i;
            mwdata_d = '0;
            starve_d = 4'd0;
          end else begin
            owner_d  = 1'b1;
            mwr_d    = ls_write_i;
            maddr_d  = ls_addr_i;
            mwdata_d = ls_write_i ? ls_wdata_i : '0;
            if (if_req_i && (starve_q != SMAX))
              starve_d = starve_q + 4'd1;
          end
        end
      end
      ISSUE: begin
        state_d  = WAIT;
        lat_d    = LAT;
        mreq_d   = 1'b0;
        mwr_d    = 1'b0;
        maddr_d  = '0;
        mwdata_d = '0;
        if (!owner_req)
          abort_d = 1'b1;
      end
      WAIT: begin
        lat_d = lat_q - 4'd1;
        if (!owner_req)
          abort_d = 1'b1;
        if (done) begin
          state_d = IDLE;
          lat_d   = 4'd0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign if_hit = done & ~owner_q & if_req_i & ~abort_q;
  assign ls_hit = done &  owner_q & ls_req_i & ~abort_q;

  assign if_rvalid_o = if_hit;
  assign if_rdata_o  = if_hit ? mem_rdata_i : '0;
  assign if_stall_o  = if_req_i & ~if_hit;

  assign ls_rvalid_o = ls_hit;
  assign ls_rdata_o  = (ls_hit & ~ls_write_i) ? mem_rdata_i : '0;
  assign ls_stall_o  = ls_req_i & ~ls_hit;

  assign mem_req_o   = mreq_q;
  assign mem_write_o = mwr_q;
  assign mem_addr_o  = maddr_q;
  assign mem_wdata_o = mwdata_q;
  assign busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter at MEM_LAT=1 and MEM_LAT=3.
// Both instances share stimulus; each step checks the relevant one.
module tb_mem_port_arbiter;

  logic        clk;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic        ls_req;
  logic        ls_write;
  logic [31:0] ls_addr;
  logic [31:0] ls_wdata;
  logic [31:0] mem_rdata;

  logic        if_stall1, if_rv1, ls_stall1, ls_rv1;
  logic        mreq1, mwr1, busy1;
  logic [31:0] if_rd1, ls_rd1, maddr1, mwd1;
  logic        if_stall3, if_rv3, ls_stall3, ls_rv3;
  logic        mreq3, mwr3, busy3;
  logic [31:0] if_rd3, ls_rd3, maddr3, mwd3;

  int total = 0;
  int bad   = 0;

  mem_port_arbiter #(.MEM_LAT(1), .STARVE_MAX(4)) dut1 (
    .clk(clk), .reset(reset),
    .if_req_i(if_req), .if_addr_i(if_addr),
    .if_stall_o(if_stall1), .if_rvalid_o(if_rv1), .if_rdata_o(if_rd1),
    .ls_req_i(ls_req), .ls_write_i(ls_write),
    .ls_addr_i(ls_addr), .ls_wdata_i(ls_wdata),
    .ls_stall_o(ls_stall1), .ls_rvalid_o(ls_rv1), .ls_rdata_o(ls_rd1),
    .mem_req_o(mreq1), .mem_write_o(mwr1),
    .mem_addr_o(maddr1), .mem_wdata_o(mwd1),
    .mem_rdata_i(mem_rdata), .busy_o(busy1)
  );

  mem_port_arbiter #(.MEM_LAT(3), .STARVE_MAX(4)) dut3 (
    .clk(clk), .reset(reset),
    .if_req_i(if_req), .if_addr_i(if_addr),
    .if_stall_o(if_stall3), .if_rvalid_o(if_rv3), .if_rdata_o(if_rd3),
    .ls_req_i(ls_req), .ls_write_i(ls_write),
    .ls_addr_i(ls_addr), .ls_wdata_i(ls_wdata),
    .ls_stall_o(ls_stall3), .ls_rvalid_o(ls_rv3), .ls_rdata_o(ls_rd3),
    .mem_req_o(mreq3), .mem_write_o(mwr3),
    .mem_addr_o(maddr3), .mem_wdata_o(mwd3),
    .mem_rdata_i(mem_rdata), .busy_o(busy3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // advance to the next cycle: inputs change 1 unit after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // move to the sampling point (falling edge) of the current cycle
  task automatic smp();
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    reset = 1'b0; if_req = 1'b0; if_addr = '0;
    ls_req = 1'b0; ls_write = 1'b0; ls_addr = '0;
    ls_wdata = '0; mem_rdata = '0;
    idle(2);
    smp();
    chk("rst_busy", {31'd0, busy1}, 32'd0);
    chk("rst_mreq", {31'd0, mreq1}, 32'd0);
    chk("rst_maddr", maddr1, 32'd0);
    chk("rst_ifrv", {31'd0, if_rv1}, 32'd0);
    chk("rst_ifst", {31'd0, if_stall1}, 32'd0);
    tick();
    reset = 1'b1;
    idle(2);

    // 1: lone fetch, MEM_LAT=1
    if_req = 1'b1; if_addr = 32'h10;
    smp();
    chk("t1_stall_t", {31'd0, if_stall1}, 32'd1);
    chk("t1_mreq_t", {31'd0, mreq1}, 32'd0);
    tick();
    mem_rdata = 32'h1234_5678;
    smp();
    chk("t1_mreq_t1", {31'd0, mreq1}, 32'd1);
    chk("t1_addr_t1", maddr1, 32'h10);
    chk("t1_stall_t1", {31'd0, if_stall1}, 32'd1);
    chk("t1_busy_t1", {31'd0, busy1}, 32'd1);
    tick();
    smp();
    chk("t1_mreq_t2", {31'd0, mreq1}, 32'd0);
    chk("t1_rv_t2", {31'd0, if_rv1}, 32'd1);
    chk("t1_rd_t2", if_rd1, 32'h1234_5678);
    chk("t1_stall_t2", {31'd0, if_stall1}, 32'd0);
    tick();
    if_req = 1'b0;
    smp();
    chk("t1_rv_t3", {31'd0, if_rv1}, 32'd0);
    chk("t1_rd_t3", if_rd1, 32'd0);
    idle(8);

    // 2: simultaneous IF and LS load, LS first
    if_req = 1'b1; if_addr = 32'h20;
    ls_req = 1'b1; ls_write = 1'b0; ls_addr = 32'h80;
    mem_rdata = 32'hCAFE_0001;
    smp();
    chk("t2_lsst_t", {31'd0, ls_stall1}, 32'd1);
    tick();
    smp();
    chk("t2_addr_t1", maddr1, 32'h80);
    chk("t2_wr_t1", {31'd0, mwr1}, 32'd0);
    chk("t2_wd_t1", mwd1, 32'd0);
    tick();
    smp();
    chk("t2_lsrv_t2", {31'd0, ls_rv1}, 32'd1);
    chk("t2_lsrd_t2", ls_rd1, 32'hCAFE_0001);
    chk("t2_lsst_t2", {31'd0, ls_stall1}, 32'd0);
    chk("t2_ifst_t2", {31'd0, if_stall1}, 32'd1);
    chk("t2_ifrv_t2", {31'd0, if_rv1}, 32'd0);
    tick();
    ls_req = 1'b0;
    mem_rdata = 32'hCAFE_0002;
    smp();
    chk("t2_ifst_t3", {31'd0, if_stall1}, 32'd1);
    tick();
    smp();
    chk("t2_mreq_t4", {31'd0, mreq1}, 32'd1);
    chk("t2_addr_t4", maddr1, 32'h20);
    chk("t2_ifst_t4", {31'd0, if_stall1}, 32'd1);
    tick();
    smp();
    chk("t2_ifrv_t5", {31'd0, if_rv1}, 32'd1);
    chk("t2_ifrd_t5", if_rd1, 32'hCAFE_0002);
    chk("t2_ifst_t5", {31'd0, if_stall1}, 32'd0);
    tick();
    if_req = 1'b0;
    idle(8);

    // 3: starvation guard; grants LS x4 then IF, then LS again
    if_req = 1'b1; if_addr = 32'h24;
    ls_req = 1'b1; ls_write = 1'b0; ls_addr = 32'h84;
    for (int k = 0; k < 6; k++) begin
      tick();
      smp();
      chk($sformatf("t3_mreq_%0d", k), {31'd0, mreq1}, 32'd1);
      chk($sformatf("t3_addr_%0d", k), maddr1,
          (k == 4) ? 32'h24 : 32'h84);
      tick();
      tick();
    end
    if_req = 1'b0; ls_req = 1'b0;
    idle(8);

    // clean restart before the MEM_LAT=3 scenarios
    reset = 1'b0;
    tick();
    reset = 1'b1;
    idle(2);

    // 4: store with MEM_LAT=3
    ls_req = 1'b1; ls_write = 1'b1;
    ls_addr = 32'h40; ls_wdata = 32'hDEAD_BEEF;
    smp();
    chk("t4_st_t", {31'd0, ls_stall3}, 32'd1);
    tick();
    smp();
    chk("t4_mreq_t1", {31'd0, mreq3}, 32'd1);
    chk("t4_wr_t1", {31'd0, mwr3}, 32'd1);
    chk("t4_addr_t1", maddr3, 32'h40);
    chk("t4_wd_t1", mwd3, 32'hDEAD_BEEF);
    tick();
    smp();
    chk("t4_mreq_t2", {31'd0, mreq3}, 32'd0);
    chk("t4_wr_t2", {31'd0, mwr3}, 32'd0);
    chk("t4_rv_t2", {31'd0, ls_rv3}, 32'd0);
    tick();
    mem_rdata = 32'hAAAA_5555;
    smp();
    chk("t4_st_t3", {31'd0, ls_stall3}, 32'd1);
    tick();
    smp();
    chk("t4_rv_t4", {31'd0, ls_rv3}, 32'd1);
    chk("t4_rd_t4", ls_rd3, 32'd0);
    chk("t4_st_t4", {31'd0, ls_stall3}, 32'd0);
    tick();
    ls_req = 1'b0; ls_write = 1'b0;
    idle(8);

    // 5: fetch aborted after grant
    if_req = 1'b1; if_addr = 32'h30;
    mem_rdata = 32'h0BAD_0BAD;
    tick();
    if_req = 1'b0;
    smp();
    chk("t5_mreq_t1", {31'd0, mreq3}, 32'd1);
    chk("t5_st_t1", {31'd0, if_stall3}, 32'd0);
    tick();
    tick();
    smp();
    chk("t5_busy_t3", {31'd0, busy3}, 32'd1);
    tick();
    smp();
    chk("t5_busy_t4", {31'd0, busy3}, 32'd1);
    chk("t5_rv_t4", {31'd0, if_rv3}, 32'd0);
    chk("t5_rd_t4", if_rd3, 32'd0);
    tick();
    smp();
    chk("t5_busy_t5", {31'd0, busy3}, 32'd0);
    chk("t5_mreq_t5", {31'd0, mreq3}, 32'd0);
    idle(4);

    // 6: asynchronous reset while in WAIT
    ls_req = 1'b1; ls_write = 1'b0; ls_addr = 32'h88;
    mem_rdata = 32'h5150_5150;
    tick();
    tick();
    smp();
    chk("t6_busy_pre", {31'd0, busy3}, 32'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("t6_busy_rst", {31'd0, busy3}, 32'd0);
    chk("t6_mreq_rst", {31'd0, mreq3}, 32'd0);
    chk("t6_addr_rst", maddr3, 32'd0);
    chk("t6_rv_rst", {31'd0, ls_rv3}, 32'd0);
    chk("t6_rd_rst", ls_rd3, 32'd0);
    chk("t6_st_rst", {31'd0, ls_stall3}, 32'd1);
    tick();
    reset = 1'b1;
    tick();
    smp();
    chk("t6_mreq_r1", {31'd0, mreq3}, 32'd1);
    chk("t6_addr_r1", maddr3, 32'h88);
    tick();
    tick();
    tick();
    smp();
    chk("t6_rv_r4", {31'd0, ls_rv3}, 32'd1);
    chk("t6_rd_r4", ls_rd3, 32'h5150_5150);
    tick();
    ls_req = 1'b0;
    idle(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
